// File: rtl/video_pkg.sv
// Shared video types and constants for the compositor slice.
// Layer words carry RGB in [24:1] and an opaque flag in [0].
package video_pkg;

  localparam int LAYER_W    = 25;
  localparam int RGB_W      = 24;
  localparam int OPAQUE_BIT = 0;

  localparam int H_ACTIVE_DEF      = 1920;
  localparam int V_ACTIVE_DEF      = 1080;
  localparam int SCORE_PER_HIT_DEF = 10;

  localparam logic [1:0] ST_BLANK  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  typedef struct packed {
    logic [LAYER_W-1:0] player;
    logic [LAYER_W-1:0] bullet;
    logic [LAYER_W-1:0] enemy;
    logic [RGB_W-1:0]   bg;
    logic               active;
  } s1_t;

  function automatic logic opaque(input logic [LAYER_W-1:0] l);
    return l[OPAQUE_BIT];
  endfunction

  function automatic logic [RGB_W-1:0] rgb(input logic [LAYER_W-1:0] l);
    return l[LAYER_W-1:1];
  endfunction

endpackage

// File: rtl/frame_stats.sv
// Per-frame hit accounting: BLANK/ACTIVE/REPORT on registered calc.
// Reports hit count, player collision pulse and saturating score.
module frame_stats
  import video_pkg::*;
#(
  parameter int SCORE_PER_HIT = SCORE_PER_HIT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        calc,
  input  logic        hit,
  input  logic        overlap_p,
  output logic        player_hit,
  output logic [7:0]  frame_hits,
  output logic [15:0] score
);

  logic [1:0]  state;
  logic        calc_q;
  logic [7:0]  hit_acc;
  logic        p_flag;
  logic [23:0] sum;
  logic        calc_rise;
  logic        calc_fall;

  assign calc_rise = calc & ~calc_q;
  assign calc_fall = ~calc & calc_q;

  // hit_acc <= 255 keeps the step at 2550, so 24 bits never wrap
  assign sum = {8'd0, score}
             + 24'(hit_acc) * 24'(SCORE_PER_HIT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_BLANK;
      calc_q     <= 1'b0;
      hit_acc    <= '0;
      p_flag     <= 1'b0;
      player_hit <= 1'b0;
      frame_hits <= '0;
      score      <= '0;
    end else begin
      calc_q     <= calc;
      player_hit <= 1'b0;
      unique case (state)
        ST_BLANK: begin
          if (calc_fall) begin
            state   <= ST_ACTIVE;
            hit_acc <= '0;
            p_flag  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (hit && hit_acc != 8'hFF)
            hit_acc <= hit_acc + 8'd1;
          p_flag <= p_flag | overlap_p;
          if (calc_rise)
            state <= ST_REPORT;
        end
        ST_REPORT: begin
          frame_hits <= hit_acc;
          player_hit <= p_flag;
          score      <= (|sum[23:16]) ? 16'hFFFF
                                      : sum[15:0];
          state      <= ST_BLANK;
        end
        default: state <= ST_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/frame_compositor.sv
// Two-stage layer compositor with hit detection and blanking window.
// Frame statistics live in frame_stats.
module frame_compositor
  import video_pkg::*;
#(
  parameter int H_ACTIVE      = H_ACTIVE_DEF,
  parameter int V_ACTIVE      = V_ACTIVE_DEF,
  parameter int SCORE_PER_HIT = SCORE_PER_HIT_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [11:0]        display_col,
  input  logic [10:0]        display_row,
  input  logic [RGB_W-1:0]   background_color,
  input  logic [LAYER_W-1:0] player_color,
  input  logic [LAYER_W-1:0] bullet_color,
  input  logic [LAYER_W-1:0] enemy_color,
  output logic [RGB_W-1:0]   pixel_color,
  output logic               pixel_valid,
  output logic               hit,
  output logic               calc,
  output logic               player_hit,
  output logic [7:0]         frame_hits,
  output logic [15:0]        score
);

  localparam logic [11:0] H_LIM = 12'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  s1_t              s1_q;
  logic             active;
  logic [RGB_W-1:0] color_d;
  logic             overlap_p;

  assign active = (display_col < H_LIM)
                & (display_row < V_LIM);

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_q <= '0;
    end else begin
      s1_q <= '{player: player_color,
                bullet: bullet_color,
                enemy:  enemy_color,
                bg:     background_color,
                active: active};
    end
  end

  always_comb begin
    color_d = s1_q.bg;
    if (opaque(s1_q.player))
      color_d = rgb(s1_q.player);
    else if (opaque(s1_q.bullet))
      color_d = rgb(s1_q.bullet);
    else if (opaque(s1_q.enemy))
      color_d = rgb(s1_q.enemy);
  end

  assign overlap_p = s1_q.active
                   & opaque(s1_q.player)
                   & opaque(s1_q.enemy);

  always_ff @(posedge clock) begin
    if (!reset) begin
      pixel_color <= '0;
      pixel_valid <= 1'b0;
      hit         <= 1'b0;
      calc        <= 1'b0;
    end else begin
      pixel_color <= s1_q.active ? color_d : '0;
      pixel_valid <= s1_q.active;
      hit         <= s1_q.active
                   & opaque(s1_q.bullet)
                   & opaque(s1_q.enemy);
      calc        <= display_row >= V_LIM;
    end
  end

  frame_stats #(
    .SCORE_PER_HIT(SCORE_PER_HIT)
  ) u_stats (
    .clock      (clock),
    .reset      (reset),
    .calc       (calc),
    .hit        (hit),
    .overlap_p  (overlap_p),
    .player_hit (player_hit),
    .frame_hits (frame_hits),
    .score      (score)
  );

endmodule

// File: tb/tb_frame_compositor.sv
// Directed bench for frame_compositor: vector table for the mux
// pipeline plus frame sequences for reset, hits, score and collisions.
module tb_frame_compositor;
  import video_pkg::*;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [11:0]        display_col = '0;
  logic [10:0]        display_row = '0;
  logic [RGB_W-1:0]   background_color = '0;
  logic [LAYER_W-1:0] player_color = '0;
  logic [LAYER_W-1:0] bullet_color = '0;
  logic [LAYER_W-1:0] enemy_color = '0;
  logic [RGB_W-1:0]   pixel_color;
  logic               pixel_valid;
  logic               hit;
  logic               calc;
  logic               player_hit;
  logic [7:0]         frame_hits;
  logic [15:0]        score;

  frame_compositor dut (
    .clock            (clock),
    .reset            (reset),
    .display_col      (display_col),
    .display_row      (display_row),
    .background_color (background_color),
    .player_color     (player_color),
    .bullet_color     (bullet_color),
    .enemy_color      (enemy_color),
    .pixel_color      (pixel_color),
    .pixel_valid      (pixel_valid),
    .hit              (hit),
    .calc             (calc),
    .player_hit       (player_hit),
    .frame_hits       (frame_hits),
    .score            (score)
  );

  always #5 clock = ~clock;

  localparam logic [11:0] HA = 12'd1920;
  localparam logic [10:0] VA = 11'd1080;

  typedef struct {
    logic [11:0]        col;
    logic [10:0]        row;
    logic [RGB_W-1:0]   bg;
    logic [LAYER_W-1:0] pl;
    logic [LAYER_W-1:0] bu;
    logic [LAYER_W-1:0] en;
    logic [RGB_W-1:0]   color;
    logic               valid;
    logic               hit;
    logic               calc;
  } vec_t;

  vec_t tv[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [LAYER_W-1:0] lay(
    input logic [23:0] c, input logic o);
    return {c, o};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_px(input logic [11:0] c,
                        input logic [10:0] r,
                        input logic [23:0] bg,
                        input logic [24:0] pl,
                        input logic [24:0] bu,
                        input logic [24:0] en);
    display_col      = c;
    display_row      = r;
    background_color = bg;
    player_color     = pl;
    bullet_color     = bu;
    enemy_color      = en;
  endtask

  task automatic tick(inout int hs);
    @(posedge clock);
    #1;
    if (hit) hs++;
  endtask

  // One frame: blank, one clean pixel, nh hit pixels, optional
  // player/enemy overlap, then blank until the report lands.
  task automatic run_frame(input int nh, input bit pov,
                           output int hs,
                           output logic ph0,
                           output logic ph1);
    hs = 0;
    set_px(12'd0, VA, 24'h0, 25'h0, 25'h0, 25'h0);
    repeat (3) tick(hs);
    set_px(12'd10, 11'd10, 24'h202020,
           lay(24'hFF0000, 1'b0), lay(24'h00FF00, 1'b0),
           lay(24'h0000FF, 1'b0));
    tick(hs);
    for (int i = 0; i < nh; i++) begin
      set_px(12'd10, 11'd10, 24'h202020,
             lay(24'hFF0000, 1'b0), lay(24'h00FF00, 1'b1),
             lay(24'h0000FF, 1'b1));
      tick(hs);
    end
    if (pov) begin
      set_px(12'd10, 11'd10, 24'h202020,
             lay(24'hFF0000, 1'b1), lay(24'h00FF00, 1'b0),
             lay(24'h0000FF, 1'b1));
      tick(hs);
    end
    set_px(12'd0, VA, 24'h0, 25'h0, 25'h0, 25'h0);
    repeat (3) tick(hs);
    ph0 = player_hit;
    tick(hs);
    ph1 = player_hit;
  endtask

  initial begin
    int   hs;
    logic ph0, ph1;
    hs = 0;

    tv[0] = '{12'd10, 11'd10, 24'h111111,
              lay(24'hFF0000, 1), lay(24'h00FF00, 1),
              lay(24'h0000FF, 1), 24'hFF0000, 1, 1, 0};
    tv[1] = '{12'd10, 11'd10, 24'h111111,
              lay(24'hFF0000, 0), lay(24'h00FF00, 1),
              lay(24'h0000FF, 1), 24'h00FF00, 1, 1, 0};
    tv[2] = '{12'd10, 11'd10, 24'h111111,
              lay(24'hFF0000, 0), lay(24'h00FF00, 0),
              lay(24'h0000FF, 1), 24'h0000FF, 1, 0, 0};
    tv[3] = '{12'd10, 11'd10, 24'h111111,
              lay(24'hFF0000, 0), lay(24'h00FF00, 0),
              lay(24'h0000FF, 0), 24'h111111, 1, 0, 0};
    tv[4] = '{12'd1919, 11'd1079, 24'h111111,
              lay(24'hFF0000, 0), lay(24'h00FF00, 1),
              lay(24'h0000FF, 1), 24'h00FF00, 1, 1, 0};
    tv[5] = '{12'd0, 11'd0, 24'h111111,
              lay(24'hFF0000, 1), lay(24'h00FF00, 0),
              lay(24'h0000FF, 1), 24'hFF0000, 1, 0, 0};
    tv[6] = '{HA, 11'd10, 24'h111111,
              lay(24'hFF0000, 1), lay(24'h00FF00, 1),
              lay(24'h0000FF, 1), 24'h000000, 0, 0, 0};
    tv[7] = '{12'd10, VA, 24'h111111,
              lay(24'hFF0000, 1), lay(24'h00FF00, 1),
              lay(24'h0000FF, 1), 24'h000000, 0, 0, 1};

    // Power-on reset with an active, overlapping pixel on the inputs
    reset = 1'b0;
    set_px(12'd10, 11'd10, 24'h111111, lay(24'hFF0000, 1),
           lay(24'h00FF00, 1), lay(24'h0000FF, 1));
    repeat (4) tick(hs);
    chk("rst_color", 32'(pixel_color), 32'h0);
    chk("rst_valid", 32'(pixel_valid), 32'h0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_calc", 32'(calc), 32'h0);
    chk("rst_phit", 32'(player_hit), 32'h0);
    chk("rst_fhits", 32'(frame_hits), 32'h0);
    chk("rst_score", 32'(score), 32'h0);
    reset = 1'b1;

    // Exact two-clock latency into and out of the active area
    repeat (2) tick(hs);
    chk("lat_in_color", 32'(pixel_color), 32'hFF0000);
    display_col = HA;
    tick(hs);
    chk("lat_hold_valid", 32'(pixel_valid), 32'h1);
    chk("lat_hold_color", 32'(pixel_color), 32'hFF0000);
    tick(hs);
    chk("lat_out_valid", 32'(pixel_valid), 32'h0);
    chk("lat_out_color", 32'(pixel_color), 32'h0);

    for (int i = 0; i < 8; i++) begin
      set_px(tv[i].col, tv[i].row, tv[i].bg,
             tv[i].pl, tv[i].bu, tv[i].en);
      repeat (2) tick(hs);
      chk($sformatf("vec%0d_color", i),
          32'(pixel_color), 32'(tv[i].color));
      chk($sformatf("vec%0d_valid", i),
          32'(pixel_valid), 32'(tv[i].valid));
      chk($sformatf("vec%0d_hit", i),
          32'(hit), 32'(tv[i].hit));
      chk($sformatf("vec%0d_calc", i),
          32'(calc), 32'(tv[i].calc));
    end
    chk("tbl_no_report", 32'(frame_hits), 32'h0);

    run_frame(3, 1'b0, hs, ph0, ph1);
    chk("f1_hit_pulses", 32'(hs), 32'd3);
    chk("f1_frame_hits", 32'(frame_hits), 32'd3);
    chk("f1_score", 32'(score), 32'd30);
    chk("f1_player_hit", 32'(ph0), 32'h0);

    // Reset mid-frame while hits are being counted
    hs = 0;
    set_px(12'd0, VA, 24'h0, 25'h0, 25'h0, 25'h0);
    repeat (3) tick(hs);
    set_px(12'd10, 11'd10, 24'h202020, lay(24'hFF0000, 0),
           lay(24'h00FF00, 1), lay(24'h0000FF, 1));
    repeat (3) tick(hs);
    reset = 1'b0;
    repeat (4) tick(hs);
    chk("mrst_color", 32'(pixel_color), 32'h0);
    chk("mrst_valid", 32'(pixel_valid), 32'h0);
    chk("mrst_hit", 32'(hit), 32'h0);
    chk("mrst_fhits", 32'(frame_hits), 32'h0);
    chk("mrst_score", 32'(score), 32'h0);
    reset = 1'b1;
    tick(hs);
    chk("rel1_valid", 32'(pixel_valid), 32'h0);
    tick(hs);
    chk("rel2_valid", 32'(pixel_valid), 32'h1);
    chk("rel2_color", 32'(pixel_color), 32'h00FF00);
    repeat (4) tick(hs);
    set_px(12'd0, VA, 24'h0, 25'h0, 25'h0, 25'h0);
    repeat (6) tick(hs);
    chk("partial_fhits", 32'(frame_hits), 32'h0);
    chk("partial_score", 32'(score), 32'h0);

    run_frame(3, 1'b0, hs, ph0, ph1);
    chk("f2_hit_pulses", 32'(hs), 32'd3);
    chk("f2_frame_hits", 32'(frame_hits), 32'd3);
    chk("f2_score", 32'(score), 32'd30);

    run_frame(0, 1'b1, hs, ph0, ph1);
    chk("coll_pulse", 32'(ph0), 32'h1);
    chk("coll_pulse_end", 32'(ph1), 32'h0);
    chk("coll_fhits", 32'(frame_hits), 32'h0);
    chk("coll_score", 32'(score), 32'd30);

    run_frame(0, 1'b0, hs, ph0, ph1);
    chk("clean_pulse", 32'(ph0), 32'h0);

    // 30 + 25*2550 + 1740 = 65520 = 16'hFFF0
    for (int f = 0; f < 25; f++) begin
      run_frame(255, 1'b0, hs, ph0, ph1);
    end
    chk("pre_fhits", 32'(frame_hits), 32'd255);
    run_frame(174, 1'b0, hs, ph0, ph1);
    chk("pre_score", 32'(score), 32'hFFF0);
    chk("pre174_fhits", 32'(frame_hits), 32'd174);

    run_frame(300, 1'b0, hs, ph0, ph1);
    chk("sat_hit_pulses", 32'(hs), 32'd300);
    chk("sat_fhits", 32'(frame_hits), 32'd255);
    chk("sat_score", 32'(score), 32'hFFFF);

    run_frame(0, 1'b0, hs, ph0, ph1);
    chk("zero_fhits", 32'(frame_hits), 32'd0);
    chk("zero_score", 32'(score), 32'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
